quad_encoder_frontend: RTL and testbench

QUAD_ENCODER_FRONTEND -- requirements
Module: quad_encoder_frontend

---
 rtl/quad_encoder_pkg.sv | 11 +
 rtl/encoder_sync.sv | 13 +
 rtl/quad_encoder_frontend.sv | 75 +++++++
 tb/tb_quad_encoder_frontend.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/quad_encoder_pkg.sv
// quad_encoder_pkg: step encoding, velocity width and quadrature decode helper.
package quad_encoder_pkg;
   localparam int VEL_W = 16;
   typedef enum logic [1:0] {STEP_NONE, STEP_INC, STEP_DEC, STEP_ILLEGAL} step_t;
   // Gray-to-binary of {a,b} makes the forward order 00,01,11,10 count 0,1,2,3.
   function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
      logic [1:0] d;
      d = {cur[1], ^cur} - {prev[1], ^prev};
      return d == 2'd1 ? STEP_INC : d == 2'd3 ? STEP_DEC : d == 2'd2 ? STEP_ILLEGAL : STEP_NONE;
   endfunction
endpackage

// File: rtl/encoder_sync.sv
// encoder_sync: 2-flop synchronizer for one raw encoder channel.
module encoder_sync (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic [1:0] ff_q;
   always_ff @(posedge clock or posedge reset)
      if (reset) ff_q <= 2'b00;
      else ff_q <= {ff_q[0], d};
   assign q = ff_q[1];
endmodule

// File: rtl/quad_encoder_frontend.sv
// quad_encoder_frontend: quadrature decode, wrapping position count and periodic
// position/velocity snapshots with a one-cycle update strobe.
module quad_encoder_frontend
   import quad_encoder_pkg::*;
#(
   parameter int UPDATE_DIV = 50000,
   parameter int VEL_MAX    = 32767
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enc_a,
   input  logic                    enc_b,
   input  logic                    invert_direction,
   input  logic                    preset_en,
   input  logic signed [31:0]      position_preset,
   input  logic                    error_clear,
   output logic signed [31:0]      position,
   output logic signed [VEL_W-1:0] velocity,
   output logic                    update_controller,
   output logic                    encoder_error
);
   localparam int TW = $clog2(UPDATE_DIV);
   localparam logic signed [31:0] VMAX = 32'(VEL_MAX);
   localparam logic signed [31:0] VMIN = -VMAX - 32'sd1;
   logic a_s, b_s, up, tick;
   logic [1:0] prev_q, warm_q, warm_d;
   logic [TW-1:0] tick_q, tick_d;
   logic signed [31:0] count_q, count_d, base_q, base_d, base_cur, inc, diff, position_d;
   logic signed [VEL_W-1:0] velocity_d, vel_sat;
   logic upd_q, err_q, err_d;
   step_t step;
   encoder_sync u_sync_a (.clock(clock), .reset(reset), .d(enc_a), .q(a_s));
   encoder_sync u_sync_b (.clock(clock), .reset(reset), .d(enc_b), .q(b_s));
   // warm_q reaches 3 once prev_q holds a real synchronized sample, not reset junk.
   always_comb begin
      warm_d = warm_q == 2'd3 ? warm_q : warm_q + 2'd1;
      step = warm_q == 2'd3 ? decode_step(prev_q, {a_s, b_s}) : STEP_NONE;
      up = (step == STEP_INC) ^ invert_direction;
      inc = (step == STEP_INC || step == STEP_DEC) ? (up ? 32'sd1 : -32'sd1) : 32'sd0;
      count_d = preset_en ? position_preset : count_q + inc;
      base_cur = preset_en ? position_preset : base_q;
      tick = tick_q == TW'(UPDATE_DIV - 1);
      tick_d = tick ? '0 : tick_q + TW'(1);
      diff = count_d - base_cur;
      vel_sat = diff > VMAX ? VEL_W'(VMAX) : diff < VMIN ? VEL_W'(VMIN) : VEL_W'(diff);
      base_d = tick ? count_d : base_cur;
      position_d = tick ? count_d : position;
      velocity_d = tick ? vel_sat : velocity;
      err_d = step == STEP_ILLEGAL ? 1'b1 : error_clear ? 1'b0 : err_q;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         prev_q <= 2'b00;
         warm_q <= 2'd0;
         tick_q <= '0;
         count_q <= '0;
         base_q <= '0;
         position <= '0;
         velocity <= '0;
         upd_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         prev_q <= {a_s, b_s};
         warm_q <= warm_d;
         tick_q <= tick_d;
         count_q <= count_d;
         base_q <= base_d;
         position <= position_d;
         velocity <= velocity_d;
         upd_q <= tick;
         err_q <= err_d;
      end
   assign update_controller = upd_q;
   assign encoder_error = err_q;
endmodule

// File: tb/tb_quad_encoder_frontend.sv
// tb_quad_encoder_frontend: two configurations driven by one stimulus stream and
// checked each cycle against a per-edge arithmetic model, plus directed literal checks.
module tb_quad_encoder_frontend;
   localparam int D0 = 10, V0 = 32767, D1 = 16, V1 = 5;
   logic clock = 1'b0, reset = 1'b1, enc_a = 1'b0, enc_b = 1'b0;
   logic invert_direction = 1'b0, preset_en = 1'b0, error_clear = 1'b0;
   logic signed [31:0] position_preset = '0;
   logic signed [31:0] pos0, pos1;
   logic signed [15:0] vel0, vel1;
   logic upd0, upd1, err0, err1;
   int errors = 0, checks = 0;
   always #5 clock = ~clock;
   quad_encoder_frontend #(.UPDATE_DIV(D0), .VEL_MAX(V0)) dut0 (
      .clock(clock), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
      .invert_direction(invert_direction), .preset_en(preset_en),
      .position_preset(position_preset), .error_clear(error_clear),
      .position(pos0), .velocity(vel0), .update_controller(upd0), .encoder_error(err0));
   quad_encoder_frontend #(.UPDATE_DIV(D1), .VEL_MAX(V1)) dut1 (
      .clock(clock), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
      .invert_direction(invert_direction), .preset_en(preset_en),
      .position_preset(position_preset), .error_clear(error_clear),
      .position(pos1), .velocity(vel1), .update_controller(upd1), .encoder_error(err1));
   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   // Model: decode at edge n sees raw samples taken at edges n-2 (current) and n-3 (previous).
   int n = 0, s;
   bit ill;
   logic [1:0] r [4];
   int mp [4] = '{0, 1, 3, 2};
   int div [2] = '{D0, D1};
   int vmax [2] = '{V0, V1};
   logic signed [31:0] m_cnt [2], m_base [2], m_pos [2], nx, bc, dl;
   int m_vel [2];
   bit m_upd [2], m_err [2];
   always @(posedge clock) begin
      #1;
      if (reset) begin
         n = 0;
         for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_base[k] = 0; m_pos[k] = 0; m_vel[k] = 0; m_upd[k] = 0; m_err[k] = 0;
         end
      end else begin
         n++;
         r[3] = r[2]; r[2] = r[1]; r[1] = r[0]; r[0] = {enc_a, enc_b};
         s = 0; ill = 0;
         if (n >= 4)
            case ((mp[r[2]] - mp[r[3]] + 4) % 4)
               1: s = 1;
               3: s = -1;
               2: ill = 1;
               default: s = 0;
            endcase
         if (invert_direction) s = -s;
         for (int k = 0; k < 2; k++) begin
            nx = preset_en ? position_preset : m_cnt[k] + s;
            bc = preset_en ? position_preset : m_base[k];
            m_upd[k] = (n % div[k]) == 0;
            if (m_upd[k]) begin
               dl = nx - bc;
               m_pos[k] = nx;
               m_vel[k] = dl > vmax[k] ? vmax[k] : dl < -vmax[k] - 1 ? -vmax[k] - 1 : int'(dl);
               m_base[k] = nx;
            end else m_base[k] = bc;
            m_cnt[k] = nx;
            m_err[k] = ill ? 1'b1 : error_clear ? 1'b0 : m_err[k];
         end
      end
      chk("dut0.position", pos0, m_pos[0]);
      chk("dut0.velocity", vel0, m_vel[0]);
      chk("dut0.update", upd0, m_upd[0]);
      chk("dut0.error", err0, m_err[0]);
      chk("dut1.position", pos1, m_pos[1]);
      chk("dut1.velocity", vel1, m_vel[1]);
      chk("dut1.update", upd1, m_upd[1]);
      chk("dut1.error", err1, m_err[1]);
   end
   logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
   int p = 0, c, rnd;
   logic signed [31:0] exp_wrap = 32'h8000_0001;
   task automatic cyc(input int k);
      repeat (k) begin @(posedge clock); #2; end
   endtask
   task automatic mv(input int d);
      p = (p + d + 4) % 4;
      {enc_a, enc_b} = seq[p];
      cyc(1);
   endtask
   task automatic wait_tick(input bit which, input string nm, output int cnt);
      cnt = 0;
      forever begin
         @(posedge clock); #1;
         cnt++;
         if ((which ? upd1 : upd0) || cnt >= 50) break;
      end
      if (!(which ? upd1 : upd0)) begin
         checks++; errors++;
         $display("FAIL %s: no update pulse within %0d cycles", nm, cnt);
      end
      #1;
   endtask
   initial begin
      cyc(3);
      reset = 1'b0;
      wait_tick(0, "first_tick", c);
      chk("first_tick_latency", c, 10);
      chk("first_tick_pos", pos0, 0);
      repeat (5) mv(1);
      wait_tick(0, "fwd_tick", c);
      chk("fwd5_pos", pos0, 5);
      chk("fwd5_vel", vel0, 5);
      cyc(1);
      chk("single_pulse", upd0, 0);
      preset_en = 1'b1; position_preset = 0;
      cyc(1);
      preset_en = 1'b0; invert_direction = 1'b1;
      repeat (3) mv(1);
      wait_tick(0, "inv_tick", c);
      chk("inv_pos", pos0, -3);
      chk("inv_vel", vel0, -3);
      invert_direction = 1'b0;
      while (seq[p] != 2'b00) mv(1);
      mv(2);
      cyc(3);
      chk("illegal_err_set", err0, 1);
      error_clear = 1'b1;
      cyc(1);
      error_clear = 1'b0;
      chk("illegal_err_clear", err0, 0);
      wait_tick(0, "illegal_tick", c);
      chk("illegal_no_count", pos0, -3);
      chk("illegal_vel", vel0, 0);
      preset_en = 1'b1; position_preset = 32'h7FFF_FFFF;
      cyc(1);
      preset_en = 1'b0;
      mv(1); mv(1);
      wait_tick(0, "wrap_tick", c);
      chk("wrap_pos", pos0, exp_wrap);
      chk("wrap_vel", vel0, 2);
      wait_tick(1, "sat_align", c);
      preset_en = 1'b1; position_preset = 0;
      cyc(1);
      preset_en = 1'b0;
      repeat (8) mv(1);
      wait_tick(1, "sat_pos_tick", c);
      chk("sat_pos_vel", vel1, 5);
      chk("sat_pos_position", pos1, 8);
      repeat (8) mv(-1);
      wait_tick(1, "sat_neg_tick", c);
      chk("sat_neg_vel", vel1, -6);
      chk("sat_neg_position", pos1, 0);
      while (seq[p] != 2'b00) mv(1);
      mv(2);
      cyc(4);
      chk("pre_reset_err", err0, 1);
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      wait_tick(0, "reset_tick", c);
      chk("reset_tick_latency", c, 10);
      chk("reset_pos", pos0, 0);
      chk("reset_vel", vel0, 0);
      chk("reset_err", err0, 0);
      repeat (1500) begin
         rnd = $urandom_range(0, 99);
         if (rnd < 5) invert_direction = ~invert_direction;
         preset_en = $urandom_range(0, 99) < 3;
         position_preset = $urandom;
         if ($urandom_range(0, 3) == 0) position_preset = 32'h7FFF_FFF0 + $urandom_range(0, 31);
         error_clear = $urandom_range(0, 99) < 6;
         reset = $urandom_range(0, 399) == 0;
         rnd = $urandom_range(0, 99);
         mv(rnd < 45 ? 1 : rnd < 80 ? -1 : rnd < 84 ? 2 : 0);
      end
      reset = 1'b0; preset_en = 1'b0; error_clear = 1'b0;
      cyc(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end
endmodule
